// File: rtl/multi_branch_sum_if.sv
// Frame-in / result-out bundle for multi_branch_sum.
// The producer/consumer side uses master; the summing block uses slave.
interface multi_branch_sum_if #(
  parameter int WIDTH    = 32,
  parameter int N_BRANCH = 4
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [N_BRANCH*WIDTH-1:0] in_branch;
  logic [N_BRANCH-1:0]       branch_mask;
  logic                      keep_acc;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          dout;
  logic                      overflow;
  logic                      busy;

  modport master (
    output in_valid, in_branch, branch_mask, keep_acc, out_ready,
    input  in_ready, out_valid, dout, overflow, busy
  );

  modport slave (
    input  in_valid, in_branch, branch_mask, keep_acc, out_ready,
    output in_ready, out_valid, dout, overflow, busy
  );
endinterface

// File: rtl/multi_branch_sum.sv
// Sequential masked sum of N_BRANCH operands, one branch per cycle, with
// optional chaining from the previous result and wrap or saturate on overflow.
module multi_branch_sum #(
  parameter int WIDTH    = 32,
  parameter int N_BRANCH = 4,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0
) (
  input logic              clk,
  input logic              rst,
  multi_branch_sum_if.slave bus
);
  localparam int IDX_W = $clog2(N_BRANCH + 1);
  localparam int SEL_W = (N_BRANCH > 1) ? $clog2(N_BRANCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_DONE} state_t;

  state_t                    r_state, w_next;
  logic [N_BRANCH*WIDTH-1:0] r_branch;
  logic [N_BRANCH-1:0]       r_mask;
  logic [WIDTH-1:0]          r_acc;
  logic [WIDTH-1:0]          r_dout;
  logic                      r_ovf;
  logic [IDX_W-1:0]          r_idx;

  logic [WIDTH-1:0]          w_br [N_BRANCH];
  logic [SEL_W-1:0]          w_sel;
  logic                      w_last;
  logic [WIDTH:0]            w_step;

  // Returns {overflow, result}; the sum is formed one bit wider than the operands.
  function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] clamp;
    logic             ovf;
    s = {1'b0, a} + {1'b0, b};
    if (SIGNED != 0) begin
      ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      clamp = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ovf   = s[WIDTH];
      clamp = '1;
    end
    add_step = {ovf, (ovf && (SATURATE != 0)) ? clamp : s[WIDTH-1:0]};
  endfunction

  for (genvar g = 0; g < N_BRANCH; g++) begin : g_split
    assign w_br[g] = r_branch[g*WIDTH +: WIDTH];
  end

  assign w_sel  = r_idx[SEL_W-1:0];
  assign w_last = (r_idx == IDX_W'(N_BRANCH));
  assign w_step = add_step(r_acc, w_br[w_sel]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_SUM;
      S_SUM:   if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // The extra SUM cycle at index N_BRANCH publishes acc into dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch <= '0;
      r_mask   <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
      r_idx    <= '0;
    end else if (r_state == S_IDLE && bus.in_valid) begin
      r_branch <= bus.in_branch;
      r_mask   <= bus.branch_mask;
      r_acc    <= bus.keep_acc ? r_dout : '0;
      r_ovf    <= 1'b0;
      r_idx    <= '0;
    end else if (r_state == S_SUM) begin
      if (w_last) begin
        r_dout <= r_acc;
      end else begin
        if (r_mask[w_sel]) begin
          r_acc <= w_step[WIDTH-1:0];
          r_ovf <= r_ovf | w_step[WIDTH];
        end
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dout      = r_dout;
  assign bus.overflow  = r_ovf;
endmodule
